// File: rtl/nbit_cmp_pkg.sv
// Shared result encoding and slice-count helper for the registered magnitude comparator.
package nbit_cmp_pkg;

    typedef enum logic [2:0] {
        CMP_NONE = 3'b000,
        CMP_LT   = 3'b001,
        CMP_EQ   = 3'b010,
        CMP_GT   = 3'b100
    } cmp_res_e;

    // Number of compare slices needed to cover n bits with slices of width w.
    function automatic int slice_count(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// One W-bit slice of the compare tree: unsigned gt/eq of its operand slices.
// Purely combinational; no state, no flow control.
module cmp_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_s,
    input  logic [W-1:0] b_s,
    output logic         gt,
    output logic         eq
);

    assign gt = (a_s > b_s);
    assign eq = (a_s == b_s);

endmodule

// File: rtl/nbit_comparator.sv
// Registered N-bit magnitude comparator with one-hot gt/eq/lt result (y2/y1/y0).
// Latency 1 cycle; no backpressure, accepts a new pair every cycle.
module nbit_comparator
    import nbit_cmp_pkg::*;
#(
    parameter int N       = 4,
    parameter int SIGNED  = 0,
    parameter int SLICE_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         y2,
    output logic         y1,
    output logic         y0,
    output logic         out_valid
);

    localparam int NS = slice_count(N, SLICE_W);
    localparam int NP = NS * SLICE_W;

    logic [N-1:0]  a_adj;
    logic [N-1:0]  b_adj;
    logic [NP-1:0] a_pad;
    logic [NP-1:0] b_pad;
    logic [NS-1:0] slice_gt;
    logic [NS-1:0] slice_eq;
    logic          decided;
    cmp_res_e      cmp_res;
    cmp_res_e      res_q;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_adj = a;
        b_adj = b;
        if (SIGNED != 0) begin
            a_adj[N-1] = ~a[N-1];
            b_adj[N-1] = ~b[N-1];
        end
    end

    assign a_pad = NP'(a_adj);
    assign b_pad = NP'(b_adj);

    for (genvar i = 0; i < NS; i++) begin : g_slice
        cmp_slice #(
            .W (SLICE_W)
        ) u_slice (
            .a_s (a_pad[i*SLICE_W +: SLICE_W]),
            .b_s (b_pad[i*SLICE_W +: SLICE_W]),
            .gt  (slice_gt[i]),
            .eq  (slice_eq[i])
        );
    end

    // Most-significant unequal slice decides; all-equal falls through to EQ.
    always_comb begin
        cmp_res = CMP_EQ;
        decided = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (!decided && !slice_eq[i]) begin
                decided = 1'b1;
                cmp_res = slice_gt[i] ? CMP_GT : CMP_LT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= CMP_NONE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res_q <= cmp_res;
            end
        end
    end

    assign {y2, y1, y0} = res_q;

endmodule

// File: tb/tb_nbit_comparator.sv
// Directed-vector bench for nbit_comparator across unsigned, signed, multi-slice and N=1 builds.
module tb_nbit_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a4u, b4u, a4s, b4s;
    logic [9:0] a10, b10;
    logic       a1, b1;
    logic       u_y2, u_y1, u_y0, u_ov;
    logic       s_y2, s_y1, s_y0, s_ov;
    logic       w_y2, w_y1, w_y0, w_ov;
    logic       o_y2, o_y1, o_y0, o_ov;
    logic [3:0] obs_u, obs_s, obs_w, obs_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nbit_comparator #(.N(4), .SIGNED(0), .SLICE_W(4)) u_dut_u (
        .clk (clk), .rst (rst), .in_valid (in_valid), .a (a4u), .b (b4u),
        .y2 (u_y2), .y1 (u_y1), .y0 (u_y0), .out_valid (u_ov));
    nbit_comparator #(.N(4), .SIGNED(1), .SLICE_W(4)) u_dut_s (
        .clk (clk), .rst (rst), .in_valid (in_valid), .a (a4s), .b (b4s),
        .y2 (s_y2), .y1 (s_y1), .y0 (s_y0), .out_valid (s_ov));
    nbit_comparator #(.N(10), .SIGNED(0), .SLICE_W(4)) u_dut_w (
        .clk (clk), .rst (rst), .in_valid (in_valid), .a (a10), .b (b10),
        .y2 (w_y2), .y1 (w_y1), .y0 (w_y0), .out_valid (w_ov));
    nbit_comparator #(.N(1), .SIGNED(0), .SLICE_W(1)) u_dut_o (
        .clk (clk), .rst (rst), .in_valid (in_valid), .a (a1), .b (b1),
        .y2 (o_y2), .y1 (o_y1), .y0 (o_y0), .out_valid (o_ov));

    assign obs_u = {u_ov, u_y2, u_y1, u_y0};
    assign obs_s = {s_ov, s_y2, s_y1, s_y0};
    assign obs_w = {w_ov, w_y2, w_y1, w_y0};
    assign obs_o = {o_ov, o_y2, o_y1, o_y0};

    // Observed/expected are {out_valid, y2, y1, y0}.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got ov/y=%b_%b expected %b_%b", tag, got[3], got[2:0], exp[3], exp[2:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_u(input int x, input int y);
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] exp;
    } vec4_t;

    vec4_t uvec[7];
    vec4_t svec[5];

    initial begin
        uvec[0] = '{4'b1000, 4'b1010, 3'b001};
        uvec[1] = '{4'b0100, 4'b1011, 3'b001};
        uvec[2] = '{4'b0011, 4'b1111, 3'b001};
        uvec[3] = '{4'b0111, 4'b0111, 3'b010};
        uvec[4] = '{4'b0000, 4'b0000, 3'b010};
        uvec[5] = '{4'b0001, 4'b0000, 3'b100};
        uvec[6] = '{4'b1111, 4'b1100, 3'b100};
        svec[0] = '{4'b1111, 4'b0001, 3'b001};
        svec[1] = '{4'b1000, 4'b0111, 3'b001};
        svec[2] = '{4'b0111, 4'b1000, 3'b100};
        svec[3] = '{4'b1010, 4'b1010, 3'b010};
        svec[4] = '{4'b1111, 4'b0000, 3'b001};

        rst = 1'b1; in_valid = 1'b1;
        a4u = 4'b1111; b4u = 4'b0000;
        a4s = 4'b0000; b4s = 4'b0000;
        a10 = '0; b10 = '0; a1 = 1'b0; b1 = 1'b0;

        // Reset wins over in_valid.
        cyc(); check("rst_cyc1", obs_u, 4'b0_000);
        cyc(); check("rst_cyc2", obs_u, 4'b0_000);
        rst = 1'b0;
        cyc(); check("post_rst_gt", obs_u, 4'b1_100);

        foreach (uvec[i]) begin
            a4u = uvec[i].a; b4u = uvec[i].b;
            cyc(); check($sformatf("unsigned_%0d", i), obs_u, {1'b1, uvec[i].exp});
        end

        // Hold: last result was 1111 vs 1100.
        in_valid = 1'b0; a4u = 4'b0000; b4u = 4'b1111;
        cyc(); check("hold", obs_u, 4'b0_100);
        cyc(); check("hold2", obs_u, 4'b0_100);
        in_valid = 1'b1;
        cyc(); check("hold_release", obs_u, 4'b1_001);

        foreach (svec[i]) begin
            a4s = svec[i].a; b4s = svec[i].b;
            cyc(); check($sformatf("signed_%0d", i), obs_s, {1'b1, svec[i].exp});
        end

        a10 = 10'h200; b10 = 10'h1FF;
        cyc(); check("wide_200_1ff", obs_w, 4'b1_100);
        a10 = 10'h0F0; b10 = 10'h0F1;
        cyc(); check("wide_0f0_0f1", obs_w, 4'b1_001);
        a10 = 10'h3FF; b10 = 10'h3FF;
        cyc(); check("wide_eq_ones", obs_w, 4'b1_010);

        a1 = 1'b1; b1 = 1'b0; cyc(); check("n1_gt", obs_o, 4'b1_100);
        a1 = 1'b0; b1 = 1'b1; cyc(); check("n1_lt", obs_o, 4'b1_001);
        a1 = 1'b1; b1 = 1'b1; cyc(); check("n1_eq", obs_o, 4'b1_010);

        for (int i = 0; i < 1000; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 1023));
            rb = (i % 8 == 0) ? ra : int'($urandom_range(0, 1023));
            a10 = ra[9:0]; b10 = rb[9:0];
            cyc(); check("wide_rand", obs_w, {1'b1, ref_u(ra, rb)});
        end

        for (int i = 0; i < 200; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 15)) - 8;
            rb = int'($urandom_range(0, 15)) - 8;
            a4s = ra[3:0]; b4s = rb[3:0];
            cyc(); check("signed_rand", obs_s, {1'b1, ref_u(ra, rb)});
        end

        // In-flight pair dropped when reset lands in the same cycle.
        a4u = 4'b0001; b4u = 4'b0010; in_valid = 1'b1; rst = 1'b1;
        cyc(); check("rst_mid_stream", obs_u, 4'b0_000);
        rst = 1'b0; in_valid = 1'b0;
        cyc(); check("rst_mid_after", obs_u, 4'b0_000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
